// File: rtl/fetch_pkg.sv
// Shared types and helpers for the C-extension fetch state logic.
package fetch_pkg;

  localparam int PARCEL_W = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_READY = 3'd2,
    S_HOLD  = 3'd3,
    S_BUF   = 3'd4
  } span_state_e;

  // A 16-bit parcel is compressed unless its two low bits are both set.
  function automatic logic is_rvc_parcel(input logic [1:0] bits);
    return (bits != 2'b11);
  endfunction

endpackage

// File: rtl/c_ext_span_fsm.sv
// Tracks a 32-bit instruction that straddles two fetch words and holds its two halves.
module c_ext_span_fsm
  import fetch_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                flush,
  input  logic                instr_valid,
  input  logic                pc_hi_half,
  input  logic                is_compressed,
  input  logic [PARCEL_W-1:0] effective_hi,
  input  logic [PARCEL_W-1:0] instr_lo,
  output logic                wait_for_fetch,
  output logic                in_progress,
  output logic                to_halfword,
  output logic                use_buffer,
  output logic [PARCEL_W-1:0] span_lo,
  output logic [PARCEL_W-1:0] span_hi
);

  span_state_e state_r;

  // Span state, its one-hot status flags and the two captured halves
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= S_IDLE;
      wait_for_fetch <= 1'b0;
      in_progress    <= 1'b0;
      to_halfword    <= 1'b0;
      use_buffer     <= 1'b0;
      span_lo        <= {PARCEL_W{1'b0}};
      span_hi        <= {PARCEL_W{1'b0}};
    end else if (flush) begin
      state_r        <= S_IDLE;
      wait_for_fetch <= 1'b0;
      in_progress    <= 1'b0;
      to_halfword    <= 1'b0;
      use_buffer     <= 1'b0;
    end else if (!stall) begin
      case (state_r)
        S_IDLE: begin
          if (pc_hi_half && !is_compressed) begin
            span_lo        <= effective_hi;
            state_r        <= S_WAIT;
            wait_for_fetch <= 1'b1;
          end
        end
        S_WAIT: begin
          if (instr_valid) begin
            span_hi        <= instr_lo;
            state_r        <= S_READY;
            wait_for_fetch <= 1'b0;
            in_progress    <= 1'b1;
          end
        end
        // Next PC is halfword-aligned and the memory word is stale, so hold one beat.
        S_READY: begin
          state_r     <= S_HOLD;
          in_progress <= 1'b0;
          to_halfword <= 1'b1;
        end
        S_HOLD: begin
          state_r     <= S_BUF;
          to_halfword <= 1'b0;
          use_buffer  <= 1'b1;
        end
        S_BUF: begin
          state_r    <= S_IDLE;
          use_buffer <= 1'b0;
        end
        default: begin
          state_r        <= S_IDLE;
          wait_for_fetch <= 1'b0;
          in_progress    <= 1'b0;
          to_halfword    <= 1'b0;
          use_buffer     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/c_ext_fetch_state.sv
// IF-stage C-extension state keeper: instruction buffer, stall history and spanning FSM
// feeding the instruction aligner.
module c_ext_fetch_state
  import fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_stall,
  input  logic                i_flush,
  input  logic [31:0]         i_instr,
  input  logic                i_instr_valid,
  input  logic [XLEN-1:0]     i_pc_reg,
  input  logic                i_is_compressed,
  input  logic                i_sel_nop,
  input  logic [31:0]         i_effective_instr,
  output logic [31:0]         o_instr_buffer,
  output logic                o_prev_was_compressed_at_lo,
  output logic                o_prev_was_compressed_at_lo_saved,
  output logic                o_stall_registered,
  output logic                o_spanning_wait_for_fetch,
  output logic                o_spanning_in_progress,
  output logic [PARCEL_W-1:0] o_spanning_buffer,
  output logic [PARCEL_W-1:0] o_spanning_second_half,
  output logic                o_spanning_to_halfword_registered,
  output logic                o_use_buffer_after_spanning
);

  logic advance_s;
  logic lo_issue_s;
  logic capture_s;
  logic unused_pc_s;

  assign advance_s   = !i_stall && !i_flush;
  assign lo_issue_s  = !i_pc_reg[1] && i_is_compressed && !i_sel_nop;
  assign capture_s   = o_spanning_wait_for_fetch && advance_s && i_instr_valid;
  assign unused_pc_s = ^{i_pc_reg[XLEN-1:2], i_pc_reg[0]};

  c_ext_span_fsm u_span_fsm (
    .clk            (i_clk),
    .rst            (i_rst),
    .stall          (i_stall),
    .flush          (i_flush),
    .instr_valid    (i_instr_valid),
    .pc_hi_half     (i_pc_reg[1]),
    .is_compressed  (i_is_compressed),
    .effective_hi   (i_effective_instr[31:16]),
    .instr_lo       (i_instr[15:0]),
    .wait_for_fetch (o_spanning_wait_for_fetch),
    .in_progress    (o_spanning_in_progress),
    .to_halfword    (o_spanning_to_halfword_registered),
    .use_buffer     (o_use_buffer_after_spanning),
    .span_lo        (o_spanning_buffer),
    .span_hi        (o_spanning_second_half)
  );

  // Buffer, previous-parcel history and stall bookkeeping; buffer survives flush
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_instr_buffer                    <= 32'h0000_0000;
      o_prev_was_compressed_at_lo       <= 1'b0;
      o_prev_was_compressed_at_lo_saved <= 1'b0;
      o_stall_registered                <= 1'b0;
    end else if (i_flush) begin
      o_prev_was_compressed_at_lo       <= 1'b0;
      o_prev_was_compressed_at_lo_saved <= 1'b0;
      o_stall_registered                <= 1'b0;
    end else begin
      o_stall_registered <= i_stall;
      if (i_stall && !o_stall_registered) begin
        o_prev_was_compressed_at_lo_saved <= o_prev_was_compressed_at_lo;
      end
      if (!i_stall) begin
        o_prev_was_compressed_at_lo <= lo_issue_s;
      end
      // The completing spanning word takes precedence over a low-half compressed issue.
      if (capture_s) begin
        o_instr_buffer <= i_instr;
      end else if (advance_s && lo_issue_s) begin
        o_instr_buffer <= i_effective_instr;
      end
    end
  end

endmodule

// File: tb/tb_c_ext_fetch_state.sv
// Directed scenarios plus a randomized run against a behavioural model of the fetch state.
module tb_c_ext_fetch_state;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst;
  logic            stall;
  logic            flush;
  logic [31:0]     instr;
  logic            instr_valid;
  logic [XLEN-1:0] pc_reg;
  logic            is_compressed;
  logic            sel_nop;
  logic [31:0]     effective_instr;
  logic [31:0]     instr_buffer;
  logic            prev_lo;
  logic            prev_lo_saved;
  logic            stall_registered;
  logic            span_wait;
  logic            span_in_progress;
  logic [15:0]     span_buffer;
  logic [15:0]     span_second;
  logic            span_to_halfword;
  logic            use_buffer_after;

  int checks;
  int errors;

  c_ext_fetch_state #(.XLEN(XLEN)) dut (
    .i_clk                             (clk),
    .i_rst                             (rst),
    .i_stall                           (stall),
    .i_flush                           (flush),
    .i_instr                           (instr),
    .i_instr_valid                     (instr_valid),
    .i_pc_reg                          (pc_reg),
    .i_is_compressed                   (is_compressed),
    .i_sel_nop                         (sel_nop),
    .i_effective_instr                 (effective_instr),
    .o_instr_buffer                    (instr_buffer),
    .o_prev_was_compressed_at_lo       (prev_lo),
    .o_prev_was_compressed_at_lo_saved (prev_lo_saved),
    .o_stall_registered                (stall_registered),
    .o_spanning_wait_for_fetch         (span_wait),
    .o_spanning_in_progress            (span_in_progress),
    .o_spanning_buffer                 (span_buffer),
    .o_spanning_second_half            (span_second),
    .o_spanning_to_halfword_registered (span_to_halfword),
    .o_use_buffer_after_spanning       (use_buffer_after)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; stall = 1'b0; flush = 1'b0; instr = 32'h0; instr_valid = 1'b0;
    pc_reg = 32'h104; is_compressed = 1'b0; sel_nop = 1'b0; effective_instr = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({instr_buffer, prev_lo, prev_lo_saved, stall_registered, span_wait, span_in_progress,
         span_buffer, span_second, span_to_halfword, use_buffer_after} !== 73'd0) begin
      errors++;
      $display("FAIL reset_state: outputs not all zero (buffer=%h span=%h/%h)",
               instr_buffer, span_buffer, span_second);
    end
    rst = 1'b0;
  endtask

  task automatic test_compressed_lo();
    pc_reg = 32'h100; is_compressed = 1'b1; sel_nop = 1'b0; effective_instr = 32'hABCD4501;
    step();
    checks++;
    if (prev_lo !== 1'b1) begin
      errors++; $display("FAIL comp_lo_prev: got %b want 1", prev_lo);
    end
    checks++;
    if (instr_buffer !== 32'hABCD4501) begin
      errors++; $display("FAIL comp_lo_buffer: got %h want abcd4501", instr_buffer);
    end
  endtask

  task automatic test_stall_capture();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (stall_registered !== 1'b1 || prev_lo_saved !== 1'b1 || prev_lo !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold[%0d]: stall_reg=%b saved=%b prev=%b want 1 1 1",
                 i, stall_registered, prev_lo_saved, prev_lo);
      end
    end
    stall = 1'b0; is_compressed = 1'b0;
    step();
    checks++;
    if (stall_registered !== 1'b0 || prev_lo_saved !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: stall_reg=%b saved=%b want 0 1", stall_registered, prev_lo_saved);
    end
  endtask

  task automatic test_span_delayed();
    pc_reg = 32'h102; is_compressed = 1'b0; effective_instr = 32'h00B3_0000; instr_valid = 1'b0;
    step();
    checks++;
    if (span_buffer !== 16'h00B3 || span_wait !== 1'b1) begin
      errors++;
      $display("FAIL span_start: buffer=%h wait=%b want 00b3 1", span_buffer, span_wait);
    end
    pc_reg = 32'h104;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (span_wait !== 1'b1 || span_in_progress !== 1'b0) begin
        errors++;
        $display("FAIL span_wait[%0d]: wait=%b ready=%b want 1 0", i, span_wait, span_in_progress);
      end
    end
    instr = 32'h1234_0513; instr_valid = 1'b1;
    step();
    checks++;
    if (span_second !== 16'h0513 || instr_buffer !== 32'h12340513 || span_in_progress !== 1'b1
        || span_wait !== 1'b0) begin
      errors++;
      $display("FAIL span_capture: second=%h buffer=%h ready=%b wait=%b want 0513 12340513 1 0",
               span_second, instr_buffer, span_in_progress, span_wait);
    end
    instr_valid = 1'b0;
    step();
    checks++;
    if ({span_wait, span_in_progress, span_to_halfword, use_buffer_after} !== 4'b0010) begin
      errors++;
      $display("FAIL span_hold: flags=%b want 0010",
               {span_wait, span_in_progress, span_to_halfword, use_buffer_after});
    end
    step();
    checks++;
    if ({span_wait, span_in_progress, span_to_halfword, use_buffer_after} !== 4'b0001) begin
      errors++;
      $display("FAIL span_buf: flags=%b want 0001",
               {span_wait, span_in_progress, span_to_halfword, use_buffer_after});
    end
    step();
    checks++;
    if ({span_wait, span_in_progress, span_to_halfword, use_buffer_after} !== 4'b0000) begin
      errors++;
      $display("FAIL span_idle: flags=%b want 0000",
               {span_wait, span_in_progress, span_to_halfword, use_buffer_after});
    end
  endtask

  task automatic test_stall_in_hold();
    pc_reg = 32'h102; is_compressed = 1'b0; effective_instr = 32'h00B3_0000;
    step();
    pc_reg = 32'h104; instr = 32'h5555_0093; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (span_to_halfword !== 1'b1 || use_buffer_after !== 1'b0) begin
        errors++;
        $display("FAIL hold_stall[%0d]: to_half=%b use_buf=%b want 1 0", i, span_to_halfword, use_buffer_after);
      end
    end
    stall = 1'b0;
    step();
    checks++;
    if (span_to_halfword !== 1'b0 || use_buffer_after !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: to_half=%b use_buf=%b want 0 1", span_to_halfword, use_buffer_after);
    end
    step();
  endtask

  task automatic test_flush_stall();
    pc_reg = 32'h102; is_compressed = 1'b0; effective_instr = 32'h00B3_0000;
    step();
    instr = 32'h7777_0113; instr_valid = 1'b1;
    pc_reg = 32'h100; is_compressed = 1'b1; sel_nop = 1'b0;
    step();
    instr_valid = 1'b0; stall = 1'b1;
    step();
    checks++;
    if (span_in_progress !== 1'b1 || prev_lo !== 1'b1 || prev_lo_saved !== 1'b1 || stall_registered !== 1'b1) begin
      errors++;
      $display("FAIL flush_setup: ready=%b prev=%b saved=%b stall_reg=%b want 1 1 1 1",
               span_in_progress, prev_lo, prev_lo_saved, stall_registered);
    end
    flush = 1'b1;
    step();
    checks++;
    if ({span_wait, span_in_progress, span_to_halfword, use_buffer_after, prev_lo, prev_lo_saved,
         stall_registered} !== 7'd0) begin
      errors++;
      $display("FAIL flush_stall: flags=%b prev=%b saved=%b stall_reg=%b want all 0",
               {span_wait, span_in_progress, span_to_halfword, use_buffer_after},
               prev_lo, prev_lo_saved, stall_registered);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_span();
    pc_reg = 32'h102; is_compressed = 1'b0; effective_instr = 32'hC0DE_0000;
    step();
    pc_reg = 32'h104;
    rst = 1'b1;
    step();
    checks++;
    if ({instr_buffer, prev_lo, prev_lo_saved, stall_registered, span_wait, span_in_progress,
         span_buffer, span_second, span_to_halfword, use_buffer_after} !== 73'd0) begin
      errors++;
      $display("FAIL reset_mid_span: buffer=%h span=%h/%h wait=%b", instr_buffer, span_buffer,
               span_second, span_wait);
    end
    rst = 1'b0;
  endtask

  // Model tracks the span as a step count through its five phases (0 = no span).
  task automatic test_random();
    logic [31:0] m_buf;
    logic        m_prev, m_saved, m_stallr;
    logic [15:0] m_lo, m_hi;
    int          m_span, old_span;
    logic        issue_lo;
    logic [72:0] exp_v, got_v;
    m_buf = 32'h0; m_prev = 1'b0; m_saved = 1'b0; m_stallr = 1'b0;
    m_lo = 16'h0; m_hi = 16'h0; m_span = 0;
    idle_inputs();
    rst = 1'b1;
    step();
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst             = ($urandom_range(0, 99) == 0);
      flush           = ($urandom_range(0, 11) == 0);
      stall           = ($urandom_range(0, 3) == 0);
      instr_valid     = ($urandom_range(0, 1) == 1);
      instr           = $urandom;
      effective_instr = $urandom;
      pc_reg          = ($urandom & 32'hFFFF_FFFC) | (32'($urandom_range(0, 1)) << 1);
      is_compressed   = ($urandom_range(0, 1) == 1);
      sel_nop         = ($urandom_range(0, 5) == 0);
      issue_lo = !pc_reg[1] && is_compressed && !sel_nop;
      if (rst) begin
        m_buf = 32'h0; m_prev = 1'b0; m_saved = 1'b0; m_stallr = 1'b0;
        m_lo = 16'h0; m_hi = 16'h0; m_span = 0;
      end else if (flush) begin
        m_prev = 1'b0; m_saved = 1'b0; m_stallr = 1'b0; m_span = 0;
      end else begin
        if (stall && !m_stallr) m_saved = m_prev;
        m_stallr = stall;
        if (!stall) begin
          m_prev = issue_lo;
          old_span = m_span;
          if (old_span == 1 && instr_valid) begin
            m_hi = instr[15:0]; m_buf = instr; m_span = 2;
          end else begin
            if (issue_lo) m_buf = effective_instr;
            if (old_span == 0 && pc_reg[1] && !is_compressed) begin
              m_lo = effective_instr[31:16]; m_span = 1;
            end else if (old_span >= 2) begin
              m_span = (old_span == 4) ? 0 : old_span + 1;
            end
          end
        end
      end
      step();
      exp_v = {m_buf, m_prev, m_saved, m_stallr, m_span == 1, m_span == 2, m_lo, m_hi,
               m_span == 3, m_span == 4};
      got_v = {instr_buffer, prev_lo, prev_lo_saved, stall_registered, span_wait, span_in_progress,
               span_buffer, span_second, span_to_halfword, use_buffer_after};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL random[%0d]: got %h want %h (span step %0d)", cyc, got_v, exp_v, m_span);
      end
    end
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle_inputs();
    test_reset();
    test_compressed_lo();
    test_stall_capture();
    test_span_delayed();
    test_stall_in_hold();
    test_flush_stall();
    test_reset_mid_span();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
